// File: rtl/elink_frame_assembler.sv
// rtl/elink_frame_assembler.sv - eLink frame assembler: per-lane SOF/COLLECT/DRAIN walk plus a show-ahead frame FIFO
module elink_frame_assembler #(
  parameter int BYTES       = 8,
  parameter int FRAME_BYTES = 14,
  parameter int PAYLOAD_OFS = 5,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic [8*BYTES-1:0]       in,
  input  logic [BYTES-1:0]         mask,
  output logic [8*FRAME_BYTES-1:0] out_frame,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         trunc_count
);
  localparam int FW = 8 * FRAME_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int TW = $clog2(BYTES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FW-1:0] asm_buf, asm_nx, done_frame;
  logic          prev_frame, prev_nx, done;
  logic [TW-1:0] ntrunc;
  logic [7:0]    lane_byte;
  logic          lane_mask;

  logic [FW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           push, pop, full, drop, wr;
  logic [CNT_W:0] tsum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      asm_buf    <= '0;
      prev_frame <= 1'b0;
    end else if (in_en) begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      asm_buf    <= asm_nx;
      prev_frame <= prev_nx;
    end
  end

  // Lanes are walked earliest-first; done_frame snapshots a completion so a later SOF in the same chunk cannot clobber it
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    asm_nx     = asm_buf;
    prev_nx    = prev_frame;
    done       = 1'b0;
    done_frame = '0;
    ntrunc     = '0;
    lane_byte  = '0;
    lane_mask  = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      lane_byte = in[8*(BYTES-i)-1 -: 8];
      lane_mask = mask[BYTES-1-i];
      case (state_nx)
        IDLE: begin
          if (lane_mask && !prev_nx) begin
            asm_nx[FW-1 -: 8] = lane_byte;
            cnt_nx            = CW'(1);
            state_nx          = COLLECT;
          end
        end
        COLLECT: begin
          if (lane_mask) begin
            for (int j = 1; j < FRAME_BYTES; j++)
              if (cnt_nx == CW'(j)) asm_nx[FW-1-8*j -: 8] = lane_byte;
            cnt_nx = cnt_nx + 1'b1;
            if (cnt_nx == CW'(FRAME_BYTES)) begin
              done       = 1'b1;
              done_frame = asm_nx;
              state_nx   = DRAIN;
            end
          end else begin
            ntrunc   = ntrunc + 1'b1;
            state_nx = IDLE;
          end
        end
        default: begin
          if (!lane_mask) state_nx = IDLE;
        end
      endcase
      prev_nx = lane_mask;
    end
  end

  always_comb begin
    out_valid = (level != '0);
    full      = (level == (AW+1)'(DEPTH));
    pop       = out_valid && out_ready;
    push      = in_en && done;
    drop      = push && full && !pop;
    wr        = push && !drop;
    out_frame = out_valid ? mem[rptr] : '0;
    out_data  = out_frame[FW-1-8*PAYLOAD_OFS -: 32];
    tsum      = {1'b0, trunc_count} + (CNT_W+1)'(ntrunc);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= done_frame;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      drop_count  <= '0;
      trunc_count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(wr) - (AW+1)'(pop);
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (in_en && ntrunc != '0) trunc_count <= tsum[CNT_W] ? '1 : tsum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_elink_frame_assembler.sv
// tb/tb_elink_frame_assembler.sv - directed self-checking bench for elink_frame_assembler
module tb_elink_frame_assembler;
  localparam int BYTES = 8;
  localparam int FB    = 14;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_en = 1'b0;
  logic         out_ready = 1'b0;
  logic [63:0]  in_d = '0;
  logic [7:0]   mask = '0;
  logic [111:0] out_frame;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [2:0]   level;
  logic [15:0]  drop_count, trunc_count;

  int errors = 0;
  int checks = 0;
  logic [7:0]   lane_d [64];
  logic         lane_m [64];
  logic [111:0] f;

  elink_frame_assembler #(.BYTES(BYTES), .FRAME_BYTES(FB), .PAYLOAD_OFS(5), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .in(in_d), .mask(mask),
    .out_frame(out_frame), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .drop_count(drop_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] exp_frame(input logic [7:0] base);
    logic [111:0] r;
    for (int k = 0; k < FB; k++) r[111-8*k -: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < 64; i++) begin
      lane_d[i] = 8'hEE;
      lane_m[i] = 1'b0;
    end
  endtask

  task automatic put_frame(input int start, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      lane_d[start+k] = base + 8'(k);
      lane_m[start+k] = 1'b1;
    end
  endtask

  task automatic emit_chunk(input int c);
    for (int i = 0; i < BYTES; i++) begin
      in_d[63-8*i -: 8] = lane_d[8*c+i];
      mask[7-i]         = lane_m[8*c+i];
    end
    in_en = 1'b1;
    @(posedge clk);
    #1;
    in_en = 1'b0;
  endtask

  task automatic send_frame(input int start, input logic [7:0] base);
    clear_lanes();
    put_frame(start, FB, base);
    for (int c = 0; c < (start + FB + 1 + 7) / 8; c++) emit_chunk(c);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_level", 128'(level), 128'(0));
    check("rst_drop", 128'(drop_count), 128'(0));
    check("rst_trunc", 128'(trunc_count), 128'(0));
    check("rst_frame", 128'(out_frame), 128'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // aligned frame
    clear_lanes();
    put_frame(0, FB, 8'h00);
    emit_chunk(0);
    check("t1_valid_early", 128'(out_valid), 128'(0));
    emit_chunk(1);
    f = exp_frame(8'h00);
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_level", 128'(level), 128'(1));
    check("t1_frame", 128'(out_frame), 128'(f));
    check("t1_data", 128'(out_data), 128'(32'h05060708));
    @(posedge clk);
    #1;
    check("t1_hold", 128'(out_frame), 128'(f));
    pop_one();
    check("t1_empty", 128'(out_valid), 128'(0));

    // unaligned frame across 3 chunks
    send_frame(3, 8'h00);
    check("t2_level", 128'(level), 128'(1));
    check("t2_frame", 128'(out_frame), 128'(f));
    check("t2_trunc", 128'(trunc_count), 128'(0));
    pop_one();

    // truncation then SOF in the same chunk
    clear_lanes();
    put_frame(0, 9, 8'hA0);
    put_frame(10, FB, 8'h30);
    for (int c = 0; c < 4; c++) emit_chunk(c);
    f = exp_frame(8'h30);
    check("t3_trunc", 128'(trunc_count), 128'(1));
    check("t3_level", 128'(level), 128'(1));
    check("t3_frame", 128'(out_frame), 128'(f));
    check("t3_data", 128'(out_data), 128'(f[71:40]));
    pop_one();

    // back-pressure: 6 frames into 4 entries
    for (int i = 0; i < 6; i++) send_frame(0, 8'(16 * (i + 1)));
    check("t4_level", 128'(level), 128'(4));
    check("t4_drop", 128'(drop_count), 128'(2));
    check("t4_head", 128'(out_frame), 128'(exp_frame(8'h10)));
    for (int i = 0; i < 4; i++) begin
      check("t4_order", 128'(out_frame), 128'(exp_frame(8'(16 * (i + 1)))));
      pop_one();
    end
    check("t4_valid", 128'(out_valid), 128'(0));
    check("t4_level0", 128'(level), 128'(0));

    // full with push and pop on the same edge
    for (int i = 0; i < 4; i++) send_frame(0, 8'(8'h70 + 8'(16 * i)));
    check("t5_full", 128'(level), 128'(4));
    clear_lanes();
    put_frame(0, FB, 8'hB0);
    emit_chunk(0);
    out_ready = 1'b1;
    emit_chunk(1);
    out_ready = 1'b0;
    check("t5_level", 128'(level), 128'(4));
    check("t5_drop", 128'(drop_count), 128'(2));
    for (int i = 0; i < 4; i++) begin
      check("t5_order", 128'(out_frame), 128'(exp_frame(8'(8'h80 + 8'(16 * i)))));
      pop_one();
    end
    check("t5_empty", 128'(level), 128'(0));

    // async reset mid-collect with a non-empty FIFO
    send_frame(0, 8'hC0);
    check("t6_pre_level", 128'(level), 128'(1));
    clear_lanes();
    put_frame(0, FB, 8'hD0);
    emit_chunk(0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", 128'(out_valid), 128'(0));
    check("t6_level", 128'(level), 128'(0));
    check("t6_drop", 128'(drop_count), 128'(0));
    check("t6_trunc", 128'(trunc_count), 128'(0));
    check("t6_frame", 128'(out_frame), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    emit_chunk(1);
    check("t6_tail_trunc", 128'(trunc_count), 128'(1));
    check("t6_tail_level", 128'(level), 128'(0));
    send_frame(0, 8'hE0);
    f = exp_frame(8'hE0);
    check("t6_new_level", 128'(level), 128'(1));
    check("t6_new_frame", 128'(out_frame), 128'(f));
    check("t6_new_data", 128'(out_data), 128'(32'hE5E6E7E8));
    pop_one();
    check("t6_new_empty", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
